// File: rtl/subservient_sram_pkg.sv
// Shared types for the subservient SRAM write-port arbiter.
//   arb_state_e     : session state (RUN, LOAD, HOLD)
//   owner_e         : which requester currently owns the SRAM write port
//   ARB_RESET_STATE : state entered on i_rst
package subservient_sram_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_e;

    localparam arb_state_e ARB_RESET_STATE = ST_HOLD;

endpackage

// File: rtl/sram_wr_skid.sv
// One-entry write skid register (valid, addr, data).
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset (empties the entry)
//   i_push              load i_addr/i_data, entry becomes valid (wins over pop)
//   i_pop               empty the entry
//   i_addr, i_data      write to capture
//   o_valid/o_addr/o_data  held entry
module sram_wr_skid #(
    parameter int AW = 9
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_data,
    output logic          o_valid,
    output logic [AW-1:0] o_addr,
    output logic [7:0]    o_data
);

    logic          valid_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    data_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (i_push) begin
            valid_q <= 1'b1;
            addr_q  <= i_addr;
            data_q  <= i_data;
        end else if (i_pop) begin
            valid_q <= 1'b0;
        end
    end

    assign o_valid = valid_q;
    assign o_addr  = addr_q;
    assign o_data  = data_q;

endmodule

// File: rtl/subservient_sram_arbiter.sv
// SRAM write-port arbiter between the subservient core and the SPI RAM loader.
// Holds the core in reset during a load session, drains pending loader writes,
// then releases the core after HOLD_CYCLES.
// Optional feature macro: SRAM_ARB_CHECKSUM_EN adds o_checksum, the modulo-256
// sum of loader write data issued to the SRAM in the current/last session.
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_load_active                      loader session active (synchronised)
//   i_core_waddr/wdata/wen             core write request
//   i_dbg_waddr/wdata/wen              loader write request
//   o_sram_waddr/wdata/wen             registered SRAM write port
//   o_core_rst                         registered core reset
//   o_loading                          high in LOAD and HOLD
//   o_load_count                       loader writes accepted, saturates at 2**AW
//   o_checksum                         (SRAM_ARB_CHECKSUM_EN only)
module subservient_sram_arbiter
    import subservient_sram_pkg::*;
#(
    parameter int AW          = 9,
    parameter int HOLD_CYCLES = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load_active,
    input  logic [AW-1:0] i_core_waddr,
    input  logic [7:0]    i_core_wdata,
    input  logic          i_core_wen,
    input  logic [AW-1:0] i_dbg_waddr,
    input  logic [7:0]    i_dbg_wdata,
    input  logic          i_dbg_wen,
    output logic [AW-1:0] o_sram_waddr,
    output logic [7:0]    o_sram_wdata,
    output logic          o_sram_wen,
    output logic          o_core_rst,
    output logic          o_loading,
    output logic [AW:0]   o_load_count
`ifdef SRAM_ARB_CHECKSUM_EN
    ,
    output logic [7:0]    o_checksum
`endif
);

    localparam int          CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_CYCLES - 1);
    localparam logic [AW:0] LOAD_MAX  = {1'b1, {AW{1'b0}}};

    arb_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          core_rst_q;
    logic          loading_q;
    logic          sram_wen_q;
    logic [AW-1:0] sram_waddr_q;
    logic [7:0]    sram_wdata_q;
    logic [AW:0]   load_count_q;

    owner_e        owner;
    logic          skid_push;
    logic          skid_pop;
    logic          skid_valid;
    logic [AW-1:0] skid_addr;
    logic [7:0]    skid_data;
    logic          issue_wen;
    logic [AW-1:0] issue_addr;
    logic [7:0]    issue_data;
    logic          dbg_accept;
    logic          dbg_issue;

    sram_wr_skid #(.AW(AW)) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (skid_push),
        .i_pop   (skid_pop),
        .i_addr  (i_dbg_waddr),
        .i_data  (i_dbg_wdata),
        .o_valid (skid_valid),
        .o_addr  (skid_addr),
        .o_data  (skid_data)
    );

    // Port grant. In RUN the core owns the port; a loader write arriving on the
    // RUN->LOAD edge is parked in the skid so the core write of that cycle can
    // still issue. Once loader-owned, the skid drains first and an incoming
    // write that collides with it takes its place, so nothing is lost.
    always_comb begin
        owner      = (state_q == ST_RUN) ? OWN_CORE : OWN_DBG;
        skid_push  = 1'b0;
        skid_pop   = 1'b0;
        issue_wen  = 1'b0;
        issue_addr = i_core_waddr;
        issue_data = i_core_wdata;
        dbg_accept = 1'b0;
        dbg_issue  = 1'b0;
        if (owner == OWN_CORE) begin
            issue_wen = i_core_wen;
            if (i_load_active && i_dbg_wen) begin
                skid_push  = 1'b1;
                dbg_accept = 1'b1;
            end
        end else begin
            dbg_accept = i_dbg_wen;
            if (skid_valid) begin
                issue_wen  = 1'b1;
                issue_addr = skid_addr;
                issue_data = skid_data;
                dbg_issue  = 1'b1;
                skid_push  = i_dbg_wen;
                skid_pop   = !i_dbg_wen;
            end else if (i_dbg_wen) begin
                issue_wen  = 1'b1;
                issue_addr = i_dbg_waddr;
                issue_data = i_dbg_wdata;
                dbg_issue  = 1'b1;
            end
        end
    end

`ifdef SRAM_ARB_CHECKSUM_EN
    logic [7:0] checksum_q;
    assign o_checksum = checksum_q;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ARB_RESET_STATE;
            cnt_q        <= HOLD_INIT;
            core_rst_q   <= 1'b1;
            loading_q    <= 1'b1;
            sram_wen_q   <= 1'b0;
            sram_waddr_q <= '0;
            sram_wdata_q <= '0;
            load_count_q <= '0;
`ifdef SRAM_ARB_CHECKSUM_EN
            checksum_q   <= '0;
`endif
        end else begin
            sram_wen_q <= issue_wen;
            if (issue_wen) begin
                sram_waddr_q <= issue_addr;
                sram_wdata_q <= issue_data;
            end
            if (dbg_accept && (load_count_q != LOAD_MAX)) begin
                load_count_q <= load_count_q + 1'b1;
            end
`ifdef SRAM_ARB_CHECKSUM_EN
            if (dbg_issue) begin
                checksum_q <= checksum_q + issue_data;
            end
`endif
            // Session entries below override the running count/sum updates.
            case (state_q)
                ST_RUN: begin
                    if (i_load_active) begin
                        state_q      <= ST_LOAD;
                        core_rst_q   <= 1'b1;
                        loading_q    <= 1'b1;
                        load_count_q <= {{AW{1'b0}}, dbg_accept};
`ifdef SRAM_ARB_CHECKSUM_EN
                        checksum_q   <= '0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (!i_load_active) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= HOLD_INIT;
                    end
                end
                ST_HOLD: begin
                    if (i_load_active) begin
                        state_q      <= ST_LOAD;
                        load_count_q <= {{AW{1'b0}}, dbg_accept};
`ifdef SRAM_ARB_CHECKSUM_EN
                        checksum_q   <= dbg_issue ? issue_data : 8'h00;
`endif
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (!skid_valid) begin
                        state_q    <= ST_RUN;
                        core_rst_q <= 1'b0;
                        loading_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ARB_RESET_STATE;
                end
            endcase
        end
    end

    assign o_sram_waddr = sram_waddr_q;
    assign o_sram_wdata = sram_wdata_q;
    assign o_sram_wen   = sram_wen_q;
    assign o_core_rst   = core_rst_q;
    assign o_loading    = loading_q;
    assign o_load_count = load_count_q;

endmodule

// File: tb/tb_subservient_sram_arbiter.sv
// Directed testbench for subservient_sram_arbiter (AW=9, HOLD_CYCLES=16).
module tb_subservient_sram_arbiter;

    localparam int AW = 9;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_load_active = 1'b0;
    logic [AW-1:0] i_core_waddr = '0;
    logic [7:0]    i_core_wdata = '0;
    logic          i_core_wen = 1'b0;
    logic [AW-1:0] i_dbg_waddr = '0;
    logic [7:0]    i_dbg_wdata = '0;
    logic          i_dbg_wen = 1'b0;
    logic [AW-1:0] o_sram_waddr;
    logic [7:0]    o_sram_wdata;
    logic          o_sram_wen;
    logic          o_core_rst;
    logic          o_loading;
    logic [AW:0]   o_load_count;
`ifdef SRAM_ARB_CHECKSUM_EN
    logic [7:0]    o_checksum;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    subservient_sram_arbiter #(.AW(AW), .HOLD_CYCLES(16)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_load_active (i_load_active),
        .i_core_waddr  (i_core_waddr),
        .i_core_wdata  (i_core_wdata),
        .i_core_wen    (i_core_wen),
        .i_dbg_waddr   (i_dbg_waddr),
        .i_dbg_wdata   (i_dbg_wdata),
        .i_dbg_wen     (i_dbg_wen),
        .o_sram_waddr  (o_sram_waddr),
        .o_sram_wdata  (o_sram_wdata),
        .o_sram_wen    (o_sram_wen),
        .o_core_rst    (o_core_rst),
        .o_loading     (o_loading),
        .o_load_count  (o_load_count)
`ifdef SRAM_ARB_CHECKSUM_EN
        ,
        .o_checksum    (o_checksum)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_run(input string tag);
        int n = 0;
        while (o_core_rst && n < 60) begin
            cycle();
            n++;
        end
        check_eq(tag, {31'd0, o_core_rst}, 32'd0);
    endtask

    initial begin
        int stray;
        logic [7:0] exp_sum;

        // ---------------- power-on ----------------
        cycle();
        check_eq("rst_core_rst", {31'd0, o_core_rst}, 32'd1);
        check_eq("rst_loading",  {31'd0, o_loading}, 32'd1);
        check_eq("rst_wen",      {31'd0, o_sram_wen}, 32'd0);
        check_eq("rst_waddr",    {23'd0, o_sram_waddr}, 32'd0);
        check_eq("rst_wdata",    {24'd0, o_sram_wdata}, 32'd0);
        check_eq("rst_count",    {22'd0, o_load_count}, 32'd0);
        cycle();
        i_rst = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            cycle();
            check_eq("hold_core_rst", {31'd0, o_core_rst}, 32'd1);
        end
        cycle();
        check_eq("run_core_rst", {31'd0, o_core_rst}, 32'd0);
        check_eq("run_loading",  {31'd0, o_loading}, 32'd0);

        // ---------------- RUN core write ----------------
        i_core_waddr = 9'h005; i_core_wdata = 8'hA5; i_core_wen = 1'b1;
        cycle();
        i_core_wen = 1'b0;
        check_eq("core_wen",   {31'd0, o_sram_wen}, 32'd1);
        check_eq("core_waddr", {23'd0, o_sram_waddr}, 32'h005);
        check_eq("core_wdata", {24'd0, o_sram_wdata}, 32'hA5);
        cycle();
        check_eq("core_wen_off", {31'd0, o_sram_wen}, 32'd0);

        // loader write outside a session is dropped
        i_dbg_waddr = 9'h033; i_dbg_wdata = 8'h77; i_dbg_wen = 1'b1;
        cycle();
        i_dbg_wen = 1'b0;
        check_eq("run_dbg_drop", {31'd0, o_sram_wen}, 32'd0);
        check_eq("run_dbg_cnt",  {22'd0, o_load_count}, 32'd0);

        // ---------------- session load ----------------
        i_load_active = 1'b1;
        cycle();
        check_eq("load_core_rst", {31'd0, o_core_rst}, 32'd1);
        check_eq("load_loading",  {31'd0, o_loading}, 32'd1);
        i_core_waddr = 9'h1FF; i_core_wdata = 8'hEE; i_core_wen = 1'b1;
        stray = 0;
        exp_sum = 8'h00;
        for (int i = 0; i < 16; i++) begin
            i_dbg_waddr = 9'(i); i_dbg_wdata = 8'(i) ^ 8'h3C; i_dbg_wen = 1'b1;
            cycle();
            i_dbg_wen = 1'b0;
            check_eq("load_wen",   {31'd0, o_sram_wen}, 32'd1);
            check_eq("load_waddr", {23'd0, o_sram_waddr}, 32'(i));
            check_eq("load_wdata", {24'd0, o_sram_wdata}, 32'(8'(i) ^ 8'h3C));
            exp_sum = exp_sum + (8'(i) ^ 8'h3C);
            for (int j = 0; j < 7; j++) begin
                cycle();
                if (o_sram_wen) stray++;
            end
        end
        check_eq("load_no_core_wr", 32'(stray), 32'd0);
        check_eq("load_count16", {22'd0, o_load_count}, 32'd16);
`ifdef SRAM_ARB_CHECKSUM_EN
        check_eq("load_checksum", {24'd0, o_checksum}, {24'd0, exp_sum});
`endif
        i_load_active = 1'b0;
        i_core_wen = 1'b0;
        wait_run("load_release");
        check_eq("count_kept", {22'd0, o_load_count}, 32'd16);

        // ---------------- collision + back-to-back ----------------
        i_load_active = 1'b1;
        i_core_waddr = 9'h010; i_core_wdata = 8'h11; i_core_wen = 1'b1;
        i_dbg_waddr  = 9'h020; i_dbg_wdata  = 8'h22; i_dbg_wen  = 1'b1;
        cycle();
        i_core_wen = 1'b0;
        check_eq("coll_core_wen",   {31'd0, o_sram_wen}, 32'd1);
        check_eq("coll_core_waddr", {23'd0, o_sram_waddr}, 32'h010);
        check_eq("coll_core_wdata", {24'd0, o_sram_wdata}, 32'h11);
        check_eq("coll_count",      {22'd0, o_load_count}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            i_dbg_waddr = 9'(32'h20 + k); i_dbg_wdata = 8'(32'h40 + k); i_dbg_wen = 1'b1;
            cycle();
            check_eq("b2b_wen", {31'd0, o_sram_wen}, 32'd1);
            if (k == 1) begin
                check_eq("coll_dbg_waddr", {23'd0, o_sram_waddr}, 32'h020);
                check_eq("coll_dbg_wdata", {24'd0, o_sram_wdata}, 32'h22);
            end else begin
                check_eq("b2b_waddr", {23'd0, o_sram_waddr}, 32'h20 + k - 1);
                check_eq("b2b_wdata", {24'd0, o_sram_wdata}, 32'h40 + k - 1);
            end
        end
        i_dbg_wen = 1'b0;
        cycle();
        check_eq("b2b_last_wen",   {31'd0, o_sram_wen}, 32'd1);
        check_eq("b2b_last_waddr", {23'd0, o_sram_waddr}, 32'h024);
        check_eq("b2b_last_wdata", {24'd0, o_sram_wdata}, 32'h44);
        cycle();
        check_eq("b2b_drained", {31'd0, o_sram_wen}, 32'd0);
        check_eq("b2b_count",   {22'd0, o_load_count}, 32'd5);

        // ---------------- re-entry from HOLD ----------------
        i_load_active = 1'b0;
        cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("reent_core_rst", {31'd0, o_core_rst}, 32'd1);
        end
        check_eq("reent_count_before", {22'd0, o_load_count}, 32'd5);
        i_load_active = 1'b1;
        cycle();
        check_eq("reent_count_clr", {22'd0, o_load_count}, 32'd0);
        check_eq("reent_core_rst2", {31'd0, o_core_rst}, 32'd1);
        check_eq("reent_loading",   {31'd0, o_loading}, 32'd1);
        i_load_active = 1'b0;
        wait_run("reent_release");

        // ---------------- reset with skid valid ----------------
        i_load_active = 1'b1;
        i_dbg_waddr = 9'h077; i_dbg_wdata = 8'h99; i_dbg_wen = 1'b1;
        cycle();
        check_eq("skid_count", {22'd0, o_load_count}, 32'd1);
        i_dbg_wen = 1'b0;
        i_rst = 1'b1;
        cycle();
        check_eq("midrst_wen",      {31'd0, o_sram_wen}, 32'd0);
        check_eq("midrst_core_rst", {31'd0, o_core_rst}, 32'd1);
        check_eq("midrst_count",    {22'd0, o_load_count}, 32'd0);
        i_rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (o_sram_wen) stray++;
        end
        check_eq("skid_discarded", 32'(stray), 32'd0);

        // ---------------- load count saturation ----------------
        for (int i = 0; i < 520; i++) begin
            i_dbg_waddr = 9'(i); i_dbg_wdata = 8'(i); i_dbg_wen = 1'b1;
            cycle();
        end
        i_dbg_wen = 1'b0;
        check_eq("count_sat", {22'd0, o_load_count}, 32'd512);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
